// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: assembles UART data bits (LSB first) into bytes and commits
// them on the stop-bit strobe to a first-word-fall-through receive FIFO that
// is drained through a valid/ready handshake. Sticky Overflow flag; optional
// stop-bit framing check enabled by defining UART_RX_FRAMING_CHECK_EN.
module uart_rx_buffer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          RXD,
  input  logic                          RX_Valid,
  input  logic                          RX_Load,
  output logic [7:0]                    Data_Out,
  output logic                          Data_Valid,
  input  logic                          Data_Ready,
  output logic                          Full,
  output logic [$clog2(FIFO_DEPTH):0]   Level,
  output logic                          Overflow,
  output logic                          Frame_Err,
  input  logic                          Clear_Err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [7:0]    sh;
  logic [3:0]    bcnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          overflow_q;

  logic frame_done;
  logic stop_ok;
  logic push_req;
  logic pop;
  logic push_acc;
  logic ovf_set;

  // Byte assembly: shift on each data-bit strobe until 8 bits are held;
  // the stop-bit strobe always restarts the bit count.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sh   <= '0;
      bcnt <= '0;
    end else if (RX_Load) begin
      bcnt <= '0;
    end else if (RX_Valid && bcnt != 4'd8) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sh   <= {RXD, sh[7:1]};
      bcnt <= bcnt + 4'd1;
    end
  end

  assign frame_done = RX_Load && (bcnt == 4'd8);

`ifdef UART_RX_FRAMING_CHECK_EN
  logic frame_err_q;

  assign stop_ok = RXD;

  // Sticky framing error: a complete frame whose stop bit reads 0.
  always_ff @(posedge Clk) begin
    if (!Rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= (frame_done && !RXD) || (frame_err_q && !Clear_Err);
  end

  assign Frame_Err = frame_err_q;
`else
  assign stop_ok   = 1'b1;
  assign Frame_Err = 1'b0;
`endif

  // Handshake decode: a simultaneous pop frees the slot a full FIFO needs.
  assign push_req = frame_done && stop_ok;
  assign pop      = Data_Valid && Data_Ready;
  assign push_acc = push_req && (!Full || pop);
  assign ovf_set  = push_req && Full && !pop;

  // Storage write port.
  always_ff @(posedge Clk) begin
    // NOTE: storage is deliberately not reset; Data_Out is masked while empty.
    if (push_acc) mem[wr_ptr] <= sh;
  end

  // Pointers and occupancy counter.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      case ({push_acc, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overflow: a set event in the same cycle as Clear_Err wins.
  always_ff @(posedge Clk) begin
    if (!Rst_n) overflow_q <= 1'b0;
    else        overflow_q <= ovf_set || (overflow_q && !Clear_Err);
  end

  assign Level      = level_q;
  assign Full       = (level_q == LW'(FIFO_DEPTH));
  assign Data_Valid = (level_q != '0);
  assign Data_Out   = Data_Valid ? mem[rd_ptr] : 8'h00;
  assign Overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed and randomized stimulus for uart_rx_buffer,
// compared each cycle against a queue-based reference model of the receive
// path. Honours UART_RX_FRAMING_CHECK_EN the same way as the design.
module tb_uart_rx_buffer;

  localparam int D  = 16;
  localparam int LW = $clog2(D) + 1;
`ifdef UART_RX_FRAMING_CHECK_EN
  localparam bit FRAMING = 1'b1;
`else
  localparam bit FRAMING = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          RXD;
  logic          RX_Valid;
  logic          RX_Load;
  logic [7:0]    Data_Out;
  logic          Data_Valid;
  logic          Data_Ready;
  logic          Full;
  logic [LW-1:0] Level;
  logic          Overflow;
  logic          Frame_Err;
  logic          Clear_Err;

  int checks = 0;
  int errors = 0;

  // Reference model: received bits so far, FIFO contents, sticky flags.
  bit       m_bits[$];
  bit [7:0] m_q[$];
  bit       m_ovf;
  bit       m_ferr;

  uart_rx_buffer #(.FIFO_DEPTH(D)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .RXD        (RXD),
    .RX_Valid   (RX_Valid),
    .RX_Load    (RX_Load),
    .Data_Out   (Data_Out),
    .Data_Valid (Data_Valid),
    .Data_Ready (Data_Ready),
    .Full       (Full),
    .Level      (Level),
    .Overflow   (Overflow),
    .Frame_Err  (Frame_Err),
    .Clear_Err  (Clear_Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 32'(Data_Valid), 32'(m_q.size() > 0));
    check({tag, ".out"},   32'(Data_Out),   (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
    check({tag, ".level"}, 32'(Level),      32'(m_q.size()));
    check({tag, ".full"},  32'(Full),       32'(m_q.size() == D));
    check({tag, ".ovf"},   32'(Overflow),   32'(m_ovf));
    check({tag, ".ferr"},  32'(Frame_Err),  32'(m_ferr));
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit rxd, input bit v, input bit l, input bit r, input bit c,
                       input string tag);
    bit       pop;
    bit       push;
    bit       fe_set;
    bit       ovf_set;
    bit [7:0] b;
    RXD = rxd; RX_Valid = v; RX_Load = l; Data_Ready = r; Clear_Err = c;
    pop = r && (m_q.size() > 0);
    push = 1'b0;
    fe_set = 1'b0;
    b = 8'h00;
    if (l) begin
      if (m_bits.size() == 8) begin
        for (int i = 0; i < 8; i++) b[i] = m_bits[i];
        if (FRAMING && !rxd) fe_set = 1'b1;
        else                 push   = 1'b1;
      end
      m_bits.delete();
    end else if (v && m_bits.size() < 8) begin
      m_bits.push_back(rxd);
    end
    ovf_set = push && (m_q.size() == D) && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !ovf_set) m_q.push_back(b);
    m_ovf  = ovf_set || (m_ovf && !c);
    m_ferr = fe_set || (m_ferr && !c);
    @(posedge Clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    RXD = 1'b1; RX_Valid = 1'b0; RX_Load = 1'b0; Data_Ready = 1'b0; Clear_Err = 1'b0;
    m_bits.delete();
    m_q.delete();
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  // Eight data strobes LSB first, then the stop-bit strobe.
  task automatic send_frame(input bit [7:0] b, input bit stop, input bit rdy_on_load,
                            input string tag);
    for (int i = 0; i < 8; i++) cycle(b[i], 1'b1, 1'b0, 1'b0, 1'b0, tag);
    cycle(stop, 1'b0, 1'b1, rdy_on_load, 1'b0, tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i <= D && m_q.size() > 0; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, tag);
    check({tag, ".empty"}, 32'(Data_Valid), 32'h0);
  endtask

  initial begin
    // Reset state.
    do_reset();
    compare_all("reset");
    check("reset.out_lit", 32'(Data_Out), 32'h00);

    // Single frame A5 appears one cycle after the load strobe.
    send_frame(8'hA5, 1'b1, 1'b0, "a5");
    check("a5.valid_lit", 32'(Data_Valid), 32'h1);
    check("a5.out_lit",   32'(Data_Out),   32'hA5);
    check("a5.level_lit", 32'(Level),      32'h1);
    drain("a5.drain");

    // Fill to full, then overflow, then clear.
    for (int i = 0; i < D; i++) send_frame(8'(i), 1'b1, 1'b0, "fill");
    check("fill.full_lit",  32'(Full),  32'h1);
    check("fill.level_lit", 32'(Level), 32'(D));
    send_frame(8'h10, 1'b1, 1'b0, "ovf");
    check("ovf.flag_lit",  32'(Overflow), 32'h1);
    check("ovf.head_lit",  32'(Data_Out), 32'h00);
    check("ovf.level_lit", 32'(Level),    32'(D));
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "clr");
    check("clr.flag_lit", 32'(Overflow), 32'h0);

    // Push and pop together while full.
    send_frame(8'h55, 1'b1, 1'b1, "pp");
    check("pp.level_lit", 32'(Level),    32'(D));
    check("pp.ovf_lit",   32'(Overflow), 32'h0);
    check("pp.head_lit",  32'(Data_Out), 32'h01);
    for (int i = 1; i < D; i++) begin
      check("pp.drain_lit", 32'(Data_Out), 32'(i));
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "pp.drain");
    end
    check("pp.last_lit", 32'(Data_Out), 32'h55);
    drain("pp.drain");

    // Stop bit read as 0.
    send_frame(8'h3C, 1'b0, 1'b0, "stop0");
`ifdef UART_RX_FRAMING_CHECK_EN
    check("stop0.level_lit", 32'(Level),     32'h0);
    check("stop0.ferr_lit",  32'(Frame_Err), 32'h1);
`else
    check("stop0.out_lit",   32'(Data_Out),  32'h3C);
    check("stop0.ferr_lit",  32'(Frame_Err), 32'h0);
`endif
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "stop0.clr");
    drain("stop0.drain");

    // Short frame is dropped silently; the next full frame is intact.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "short");
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "short");
    check("short.level_lit", 32'(Level),    32'h0);
    check("short.ovf_lit",   32'(Overflow), 32'h0);
    send_frame(8'h81, 1'b1, 1'b0, "f81");
    check("f81.out_lit", 32'(Data_Out), 32'h81);
    drain("f81.drain");

    // Randomized traffic, including load/valid collisions and clear/set races.
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 29) == 0), "rand");
    end

    // Reset mid-frame with bytes queued.
    drain("pre_rst.drain");
    for (int i = 0; i < 3; i++) send_frame(8'(8'h20 + i), 1'b1, 1'b0, "pre_rst");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pre_rst");
    do_reset();
    check("rst.valid_lit", 32'(Data_Valid), 32'h0);
    check("rst.full_lit",  32'(Full),       32'h0);
    check("rst.level_lit", 32'(Level),      32'h0);
    check("rst.ovf_lit",   32'(Overflow),   32'h0);
    check("rst.ferr_lit",  32'(Frame_Err),  32'h0);
    check("rst.out_lit",   32'(Data_Out),   32'h00);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rst.short");
    check("rst.short_lit", 32'(Level), 32'h0);
    send_frame(8'hC3, 1'b1, 1'b0, "fc3");
    check("fc3.out_lit", 32'(Data_Out), 32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Byte assembly and receive FIFO stage directly downstream of the UART receiver FSM. Samples `RXD` on each per-bit sample strobe `RX_Valid` and shifts the bits LSB-first into a byte. On the stop-bit strobe `RX_Load` it commits the byte to a first-word-fall-through FIFO, which the microcontroller drains through a valid/ready handshake. Reports overflow and, optionally, framing errors as sticky flags.

## Interface
- `FIFO_DEPTH`, default 16: number of byte entries; power of two, ≥ 2.
- `Clk`  in  1: single clock; all logic on posedge.
- `Rst_n`  in  1: synchronous, active-low reset.
- `RXD`  in  1: serial line, same signal seen by the receiver FSM.
- `RX_Valid`  in  1: one-cycle strobe at mid-bit of each data bit (8 per frame).
- `RX_Load`  in  1: one-cycle strobe at mid-stop-bit; frame complete.
- `Data_Out`  out  8: FIFO head byte; valid only while `Data_Valid`=1.
- `Data_Valid`  out  1: FIFO non-empty.
- `Data_Ready`  in  1: consumer accepts the head; pop when `Data_Valid & Data_Ready`.
- `Full`  out  1: Level == FIFO_DEPTH.
- `Level`  out  $clog2(FIFO_DEPTH)+1: current occupancy.
- `Overflow`  out  1: sticky; a completed byte was lost because the FIFO was full.
- `Frame_Err`  out  1: sticky; stop bit sampled as 0 (see Configuration).
- `Clear_Err`  in  1: clears `Overflow` and `Frame_Err`.

## Operation
- Shift register `sh[7:0]`: on `RX_Valid`, `sh <= {RXD, sh[7:1]}` (first received bit ends in `sh[0]`). Bit counter `bcnt` (0..8) increments and saturates at 8. Further `RX_Valid` strobes at 8 are ignored.
- On `RX_Load`:
  - If `bcnt`==8 and the frame is good, request a push of `sh`.
  - Otherwise (short frame) the byte is discarded silently.
  - `bcnt` is cleared in every case.
- `RX_Load` and `RX_Valid` in the same cycle: `RX_Load` wins and `RX_Valid` is ignored.
- FIFO uses circular read/write pointers of $clog2(FIFO_DEPTH) bits each, wrapping modulo FIFO_DEPTH. `Level` is a counter.
  - Push only: accepted if not `Full`, otherwise dropped and `Overflow`<=1.
  - Pop only: accepted if `Data_Valid`.
  - Push and pop in the same cycle: both accepted even when `Full`, because the pop frees a slot. `Level` is unchanged.
  - Pop while empty is ignored. `Data_Ready` is a don't-care when `Data_Valid`=0.
- Sticky flags: `Clear_Err` clears them. A set event in the same cycle as `Clear_Err` wins, so the flag reads 1.
- Reset values: `Data_Valid`=0, `Full`=0, `Level`=0, `Overflow`=0, `Frame_Err`=0. `Data_Out`=8'h00, `sh`=0, `bcnt`=0, both pointers=0.
- Reset mid-frame discards the partial byte and all FIFO contents. The next `RX_Load` without 8 preceding `RX_Valid` strobes is treated as a short frame.

## Timing
- Push latency: `RX_Load` in cycle N gives the byte in the FIFO at N+1. If the FIFO was empty, `Data_Valid`=1 and `Data_Out` equals the byte in cycle N+1.
- Pop: the handshake in cycle N makes the next head (or `Data_Valid`=0) visible at N+1.
- `Data_Out` is driven combinationally from the storage array at the read pointer, with no extra register stage.
- `Full`, `Level` and the flags are registered and update one cycle after the causing event.
- Throughput: one byte per frame in and one byte per cycle out.

## Configuration
- `UART_RX_FRAMING_CHECK_EN` defined:
  - `RXD` is sampled in the `RX_Load` cycle.
  - If it reads 0, the byte is not pushed and `Frame_Err`<=1.
  - If it reads 1, the byte is pushed normally.
- Macro undefined:
  - The stop bit is not checked and every 8-bit frame is pushed.
  - `Frame_Err` is tied to 0 and `Clear_Err` affects only `Overflow`.

## Test plan
- Drive 8 `RX_Valid` strobes with RXD = 1,0,1,0,0,1,0,1, then `RX_Load` with RXD=1 and `Data_Ready`=0 → next cycle `Data_Valid`=1, `Data_Out`=8'hA5, `Level`=1.
- Push bytes 0x00..0x0F with `Data_Ready`=0, then push 0x10 → `Full`=1 and `Level`=16 after the 16th push. After the 17th, `Overflow`=1, head is still 0x00 and `Level` stays 16. Assert `Clear_Err` → `Overflow`=0.
- FIFO full and `Data_Ready`=1 in the same cycle as an `RX_Load` of 0x55 → 0x00 is popped and 0x55 is stored. `Level` stays 16 and `Overflow` stays 0. Draining returns 0x01..0x0F, 0x55.
- Macro defined: frame 0x3C with RXD=0 at `RX_Load` → no push, `Level`=0, `Frame_Err`=1. Macro undefined: the same stimulus gives `Data_Out`=8'h3C and `Frame_Err`=0.
- Short frame: 5 `RX_Valid` strobes then `RX_Load` → nothing pushed and no flag set. A following full frame 0x81 is received correctly.
- Assert `Rst_n`=0 for one cycle after 4 `RX_Valid` strobes, with 3 bytes queued → all outputs return to reset values. A following full frame 0xC3 is received as 0xC3.
